// File: rtl/mc_pricing_engine.sv
// mc_pricing_engine: Monte Carlo GBM option pricer, 2^LOG2_PATHS paths of a configurable step count, mean call/put payoff.
module mc_pricing_engine #(
  parameter int CFG_W      = 16,
  parameter int EPS_W      = 13,
  parameter int PRICE_W    = 16,
  parameter int FRAC       = 10,
  parameter int LOG2_PATHS = 8,
  parameter int MAX_STEPS  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_we,
  input  logic [2:0]              cfg_addr,
  input  logic [CFG_W-1:0]        cfg_data,
  input  logic                    start,
  input  logic signed [EPS_W-1:0] eps,
  input  logic                    eps_valid,
  output logic                    eps_ready,
  output logic                    busy,
  output logic                    done,
  output logic [PRICE_W-1:0]      price
);
  localparam int SW = $clog2(MAX_STEPS) + 1;
  localparam int CW = FRAC + 2;
  localparam int PW = CW + 1 + EPS_W;
  localparam int FW = PW - FRAC;
  localparam int MW = PRICE_W + FW;
  localparam int AW = PRICE_W + LOG2_PATHS;
  localparam logic [SW-1:0] MAXS = SW'(MAX_STEPS);
  typedef enum logic [2:0] {IDLE, EPS, UPD, PAY, FIN} state_t;
  state_t state_q, state_d;
  logic [PRICE_W-1:0] s0_q, s0_d, k_q, k_d, s_q, s_d, price_q, price_d;
  logic [CW-1:0] w_q, w_d, q_q, q_d;
  logic [SW-1:0] steps_q, steps_d, step_q, step_d, sraw, steps_in, step_inc;
  logic mode_q, mode_d, busy_q, busy_d, done_q, done_d, eps_ready_q, eps_ready_d, cfg_ok;
  logic [LOG2_PATHS-1:0] path_q, path_d;
  logic [AW-1:0] acc_q, acc_d, acc_sum;
  logic [FW-1:0] factor_q, factor_d;
  logic signed [PW-1:0] prod;
  logic signed [FW:0] fsum;
  logic [MW-1:0] scaled;
  logic [PRICE_W-1:0] s_next, payoff;
  assign cfg_ok   = cfg_we && (state_q == IDLE);
  assign sraw     = cfg_data[SW-1:0];
  assign steps_in = (sraw == '0 || sraw > MAXS) ? MAXS : sraw;
  assign step_inc = step_q + SW'(1);
  // factor = w + (q*eps)>>>FRAC; fits FW+1 signed bits for any Q2.10 w/q and Q3.10 eps
  assign prod     = PW'($signed({1'b0, q_q})) * PW'(eps);
  assign fsum     = (FW+1)'($signed({1'b0, w_q})) + (FW+1)'(prod >>> FRAC);
  assign scaled   = (MW'(s_q) * MW'(factor_q)) >> FRAC;
  assign s_next   = |scaled[MW-1:PRICE_W] ? '1 : scaled[PRICE_W-1:0];
  assign payoff   = mode_q ? ((k_q > s_q) ? k_q - s_q : '0) : ((s_q > k_q) ? s_q - k_q : '0);
  assign acc_sum  = acc_q + AW'(payoff);
  always_comb begin
    s0_d     = (cfg_ok && cfg_addr == 3'd0) ? cfg_data[PRICE_W-1:0] : s0_q;
    k_d      = (cfg_ok && cfg_addr == 3'd1) ? cfg_data[PRICE_W-1:0] : k_q;
    w_d      = (cfg_ok && cfg_addr == 3'd2) ? cfg_data[CW-1:0] : w_q;
    q_d      = (cfg_ok && cfg_addr == 3'd3) ? cfg_data[CW-1:0] : q_q;
    steps_d  = (cfg_ok && cfg_addr == 3'd4) ? steps_in : steps_q;
    mode_d   = (cfg_ok && cfg_addr == 3'd5) ? cfg_data[0] : mode_q;
    state_d  = state_q;
    s_d      = s_q;
    step_d   = step_q;
    path_d   = path_q;
    acc_d    = acc_q;
    factor_d = factor_q;
    price_d  = price_q;
    unique case (state_q)
      IDLE: if (start) begin
        state_d = EPS;
        s_d     = s0_d;
        step_d  = '0;
        path_d  = '0;
        acc_d   = '0;
      end
      EPS: if (eps_valid) begin
        factor_d = fsum[FW] ? '0 : fsum[FW-1:0];
        state_d  = UPD;
      end
      UPD: begin
        s_d     = s_next;
        step_d  = step_inc;
        state_d = (step_inc == steps_q) ? PAY : EPS;
      end
      PAY: begin
        acc_d = acc_sum;
        if (&path_q) begin
          state_d = FIN;
          price_d = acc_sum[AW-1:LOG2_PATHS];
        end else begin
          path_d  = path_q + LOG2_PATHS'(1);
          s_d     = s0_q;
          step_d  = '0;
          state_d = EPS;
        end
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d      = state_d != IDLE;
    done_d      = state_d == FIN;
    eps_ready_d = state_d == EPS;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      s0_q        <= '0;
      k_q         <= '0;
      w_q         <= CW'(1 << FRAC);
      q_q         <= '0;
      steps_q     <= SW'(1);
      mode_q      <= 1'b0;
      s_q         <= '0;
      step_q      <= '0;
      path_q      <= '0;
      acc_q       <= '0;
      factor_q    <= '0;
      price_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      eps_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      s0_q        <= s0_d;
      k_q         <= k_d;
      w_q         <= w_d;
      q_q         <= q_d;
      steps_q     <= steps_d;
      mode_q      <= mode_d;
      s_q         <= s_d;
      step_q      <= step_d;
      path_q      <= path_d;
      acc_q       <= acc_d;
      factor_q    <= factor_d;
      price_q     <= price_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      eps_ready_q <= eps_ready_d;
    end
  end
  assign eps_ready = eps_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign price     = price_q;
endmodule

// File: doc/mc_pricing_engine.md
Name: mc_pricing_engine

Overview:
Parametrised Monte Carlo option-pricing engine. It runs 2^LOG2_PATHS geometric-Brownian paths of a run-time-selectable step count, consuming one normal sample per step. It evaluates a call or put payoff per path and outputs the mean payoff. It sits between the quasi-random normal source (Sobol/ICDF) and the chip-level control, replacing the fixed single-path path-generation/pricing chain with a configurable, handshaked engine.

Parameters:
CFG_W, 16, config data width.
EPS_W, 13, signed normal-sample width, Q3.10.
PRICE_W, 16, unsigned price width, Q8.8 (S0, K, path value, price).
FRAC, 10, fraction bits of w, q, eps.
LOG2_PATHS, 8, log2 of path count per run.
MAX_STEPS, 16, maximum steps per path; must be a power of 2.

Ports:
clk  in  1  clock.
rst_n  in  1  reset, synchronous, active-low.
cfg_we  in  1  config write strobe.
cfg_addr  in  3  register select: 0 S0, 1 K, 2 w, 3 q, 4 steps, 5 mode.
cfg_data  in  CFG_W  write data.
start  in  1  one-cycle run request.
eps  in  EPS_W  signed normal sample.
eps_valid  in  1  sample available.
eps_ready  out  1  engine accepts a sample this cycle.
busy  out  1  run in progress.
done  out  1  one-cycle pulse: price valid.
price  out  PRICE_W  mean payoff, Q8.8, held until the next done.

Behaviour:
- All state is updated on posedge clk. rst_n low at an edge produces the following, including mid-run:
  - FSM returns to IDLE; counters and accumulator are cleared.
  - busy=0, done=0, eps_ready=0, price=0.
  - Config resets to S0=0, K=0, w=1024 (1.0), q=0, steps=1, mode=0 (call).
- Config writes:
  - Accepted only when busy=0; ignored while busy.
  - w and q take cfg_data[11:0], unsigned Q2.10.
  - steps takes cfg_data[log2(MAX_STEPS):0]. A value of 0, or a value above MAX_STEPS, is stored as MAX_STEPS.
  - mode takes cfg_data[0]: 0 = call, 1 = put.
  - A write addressed to 6 or 7 is ignored.
- start is ignored while busy. If start and cfg_we occur in the same idle cycle, the write lands first and the run uses the new value.
- FSM states: IDLE, EPS, UPD, PAY, FIN.
  - IDLE: on start, set S=S0, step=0, path=0, acc=0, busy=1, and go to EPS.
  - EPS: eps_ready=1. On eps_valid, register factor = w + ((q*eps)>>>FRAC), signed arithmetic shift, and go to UPD. A negative factor is clamped to 0. With no eps_valid, stay in EPS (stall; no other state changes).
  - UPD: S = (S*factor)>>FRAC, truncated and saturated to 2^PRICE_W-1. step++. If step==steps, go to PAY; else go to EPS.
  - PAY: payoff = max(S-K,0) for call, max(K-S,0) for put. acc += payoff. If path==2^LOG2_PATHS-1, go to FIN. Otherwise path++, S=S0, step=0, and go to EPS.
  - FIN: price = acc>>LOG2_PATHS (truncate), done=1 for this cycle, busy=0, go to IDLE.
- Accumulator width is PRICE_W+LOG2_PATHS and cannot overflow.
- eps_ready is asserted only in EPS. A sample is consumed exactly when eps_ready && eps_valid. Exactly steps*2^LOG2_PATHS samples are consumed per run.
- Latency with eps_valid held high: 2*steps+1 cycles per path, plus 1 cycle for FIN, measured from the cycle after start to done.
- busy is high from the cycle after start through the FIN cycle, inclusive.

Test Plan:
1. LOG2_PATHS=2. Config w=1024, q=0, S0=0x6400, K=0x5A00, steps=4, call. Start with eps always valid -> 16 samples consumed, done at cycle 37, price=0x0A00. Repeat with put -> price=0x0000.
2. LOG2_PATHS=2. Config w=1024, q=512, steps=1, S0=K=0x6400. eps sequence +1024, -1024, +1024, -1024. Call -> price=0x1900. Put -> price=0x1900.
3. Factor clamp: q=1024, eps=-2048 for every sample, K=0x0A00, put -> every S_T=0, price=0x0A00.
4. Saturation: w=4095, q=0, S0=0xC800, steps=4, call, K=0 -> price=0xFFFF.
5. eps_valid toggled pseudo-randomly, plus start pulses and cfg writes during busy -> identical price to the unstalled run, config unchanged, exactly one done. steps written as 0 -> MAX_STEPS steps are run.
6. rst_n low mid-run in EPS and in UPD -> next cycle busy=0, eps_ready=0, price=0, config at reset values. A fresh start then completes correctly.
